// File: rtl/sr_cmd_gen.sv
// Command stage for the clocked SR flip-flop: synchronises and debounces two raw
// buttons and turns each debounced press into a clean, mutually exclusive S or R pulse.
module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    output logic S,
    output logic R,
    output logic conflict,
    output logic overrun
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SET,
        CLR
    } state_t;

    // Bit 0 carries the set button, bit 1 the clear button.
    logic [1:0]    btn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];
    state_t        state;
    logic [PW-1:0] pulse_cnt;

    assign btn   = {rst_btn, set_btn};
    assign press = stable & ~stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // The stable level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // S and R follow the state being entered, so they rise on the edge that accepts a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            S         <= 1'b0;
            R         <= 1'b0;
            conflict  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
            overrun  <= 1'b0;
            case (state)
                IDLE: begin
                    if (press[0] && press[1]) begin
                        conflict <= 1'b1;
                    end else if (press[0]) begin
                        state     <= SET;
                        pulse_cnt <= PULSE_LOAD;
                        S         <= 1'b1;
                    end else if (press[1]) begin
                        state     <= CLR;
                        pulse_cnt <= PULSE_LOAD;
                        R         <= 1'b1;
                    end
                end
                SET, CLR: begin
                    overrun <= |press;
                    if (pulse_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt - PW'(1);
                        S         <= (state == SET);
                        R         <= (state == CLR);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
